// File: rtl/ex_mem_register.sv
// ex_mem_register: execute->memory pipeline register with a 2-entry skid buffer.
// The memory stage is always fed from the main entry. The skid entry absorbs one
// beat of back-pressure so that in_ready comes straight from a flop.
// Ports:
//   clk, rst (async, active-high), flush
//   in_valid/in_ready        : EX-side handshake
//   alu_result, comp_result, store_data, branch_target, rd_addr, wb_en,
//   mem_op, is_branch        : EX payload
//   out_valid/out_ready      : MEM-side handshake
//   out_*                    : registered payload, including out_branch_taken
module ex_mem_register #(
    parameter int OPERAND_LENGTH  = 32,
    parameter int REG_ADDR_LENGTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPERAND_LENGTH-1:0]  alu_result,
    input  logic [OPERAND_LENGTH-1:0]  comp_result,
    input  logic [OPERAND_LENGTH-1:0]  store_data,
    input  logic [OPERAND_LENGTH-1:0]  branch_target,
    input  logic [REG_ADDR_LENGTH-1:0] rd_addr,
    input  logic                       wb_en,
    input  logic [1:0]                 mem_op,
    input  logic                       is_branch,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPERAND_LENGTH-1:0]  out_alu_result,
    output logic [OPERAND_LENGTH-1:0]  out_comp_result,
    output logic [OPERAND_LENGTH-1:0]  out_store_data,
    output logic [OPERAND_LENGTH-1:0]  out_branch_target,
    output logic [REG_ADDR_LENGTH-1:0] out_rd_addr,
    output logic                       out_wb_en,
    output logic [1:0]                 out_mem_op,
    output logic                       out_branch_taken
);

    typedef struct packed {
        logic [OPERAND_LENGTH-1:0]  alu;
        logic [OPERAND_LENGTH-1:0]  comp;
        logic [OPERAND_LENGTH-1:0]  store;
        logic [OPERAND_LENGTH-1:0]  target;
        logic [REG_ADDR_LENGTH-1:0] rd;
        logic                       wb_en;
        logic [1:0]                 mem_op;
        logic                       taken;
    } beat_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    beat_t  r_main;
    beat_t  r_skid;
    beat_t  w_in;
    logic   r_in_ready;
    logic   w_accept;
    logic   w_drain;
    logic   w_load_main_in;
    logic   w_load_main_skid;
    logic   w_load_skid;

    // Normalise the incoming beat: reserved mem_op folds to "none",
    // branch outcome resolved here so MEM sees a single bit.
    always_comb begin
        w_in        = '0;
        w_in.alu    = alu_result;
        w_in.comp   = comp_result;
        w_in.store  = store_data;
        w_in.target = branch_target;
        w_in.rd     = rd_addr;
        w_in.wb_en  = wb_en;
        w_in.mem_op = (mem_op == 2'b11) ? 2'b00 : mem_op;
        w_in.taken  = is_branch & comp_result[0];
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = (r_state != S_EMPTY) & out_ready;

    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        // Flush overrides everything; the incoming beat is dropped.
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_next         = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_next      = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_next = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_drain) begin
                        w_next           = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            // Registered ready: look ahead at the next occupancy.
            r_in_ready <= (w_next != S_TWO);
        end
    end

    // Payload flops only move on an actual load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in;
            end
        end
    end

    assign in_ready          = r_in_ready;
    assign out_valid         = (r_state != S_EMPTY);
    assign out_alu_result    = r_main.alu;
    assign out_comp_result   = r_main.comp;
    assign out_store_data    = r_main.store;
    assign out_branch_target = r_main.target;
    assign out_rd_addr       = r_main.rd;
    assign out_wb_en         = r_main.wb_en;
    assign out_mem_op        = r_main.mem_op;
    assign out_branch_taken  = r_main.taken;

endmodule
